// File: rtl/cpj_readout.sv
// Readout controller for the frequency meter's byte-muxed result port.
// It collects Nx and Ns one byte at a time, then computes fx = Nx*FSTD/Ns with a bit-serial divider.
module cpj_readout #(
  parameter int unsigned FSTD   = 50000000,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clkin,
  input  logic        clr0,
  input  logic        int1,
  input  logic [7:0]  out8,
  output logic [2:0]  sel,
  output logic        busy,
  output logic [31:0] nx,
  output logic [31:0] ns,
  output logic [31:0] freq,
  output logic        valid,
  output logic        div0,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, SETW, CAP, MUL, DIV, DONE} st_e;

  localparam logic [63:0] FSTD64 = 64'(FSTD);
  localparam logic [3:0]  WLAST  = 4'(SETTLE - 1);

  st_e         st_q, st_d;
  logic        s1_q, s2_q, prev_q;
  logic [2:0]  k_q;
  logic [3:0]  wcnt_q;
  logic [5:0]  cnt_q;
  logic [31:0] nx_sh_q, ns_sh_q;
  logic [63:0] rem_q, quo_q;
  logic [31:0] nx_q, ns_q, freq_q;
  logic        div0_q, ovf_q;

  // The synchronizer resets high so that an int1 already high at release is not taken as a rise.
  always_ff @(posedge clkin or posedge clr0)
    if (clr0) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= int1;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end

  logic rise;
  assign rise = s2_q & ~prev_q;

  // A single restoring step: the borrow out of the 65-bit difference decides the quotient bit.
  logic [64:0] r_sh, diff;
  logic        ge;
  logic [63:0] rem_d, quo_d;
  always_comb begin
    r_sh  = {rem_q, quo_q[63]};
    diff  = r_sh - {33'b0, ns_sh_q};
    ge    = ~diff[64];
    rem_d = ge ? diff[63:0] : r_sh[63:0];
    quo_d = {quo_q[62:0], ge};
  end

  always_ff @(posedge clkin or posedge clr0)
    if (clr0) st_q <= IDLE;
    else      st_q <= st_d;

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (rise) st_d = SETW;
      SETW: if (!s2_q) st_d = IDLE;
            else if (wcnt_q == WLAST) st_d = CAP;
      CAP:  if (!s2_q) st_d = IDLE;
            else if (k_q == 3'd7) st_d = MUL;
            else st_d = SETW;
      MUL:  st_d = (ns_sh_q == 32'd0) ? DONE : DIV;
      DIV:  if (cnt_q == 6'd63) st_d = DONE;
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    sel   = (st_q == SETW || st_q == CAP) ? k_q : 3'd0;
    busy  = (st_q != IDLE);
    valid = (st_q == DONE);
  end

  // Result registers load on the edge into DONE, so they are already current during the valid cycle.
  always_ff @(posedge clkin or posedge clr0)
    if (clr0) begin
      k_q     <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      nx_sh_q <= '0;
      ns_sh_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      nx_q    <= '0;
      ns_q    <= '0;
      freq_q  <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          k_q    <= '0;
          wcnt_q <= '0;
        end
        SETW: wcnt_q <= (wcnt_q == WLAST) ? 4'd0 : wcnt_q + 4'd1;
        CAP: begin
          if (k_q[2]) ns_sh_q[{k_q[1:0], 3'b000} +: 8] <= out8;
          else        nx_sh_q[{k_q[1:0], 3'b000} +: 8] <= out8;
          k_q <= k_q + 3'd1;
        end
        MUL: begin
          quo_q <= 64'(nx_sh_q) * FSTD64;
          rem_q <= '0;
          cnt_q <= '0;
          if (ns_sh_q == 32'd0) begin
            nx_q   <= nx_sh_q;
            ns_q   <= ns_sh_q;
            freq_q <= '1;
            div0_q <= 1'b1;
            ovf_q  <= 1'b0;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            nx_q   <= nx_sh_q;
            ns_q   <= ns_sh_q;
            freq_q <= (|quo_d[63:32]) ? '1 : quo_d[31:0];
            div0_q <= 1'b0;
            ovf_q  <= |quo_d[63:32];
          end
        end
        default: ;
      endcase
    end

  assign nx   = nx_q;
  assign ns   = ns_q;
  assign freq = freq_q;
  assign div0 = div0_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cpj_readout.sv
// Bench for cpj_readout: a byte-muxed meter model feeds the DUT, and each result is
// compared with the value Nx*FSTD/Ns computed directly in 64-bit arithmetic.
module tb_cpj_readout;
  localparam int unsigned FSTD   = 50000000;
  localparam int unsigned SETTLE = 2;

  logic        clkin = 1'b0, clr0 = 1'b1, int1 = 1'b0;
  logic [7:0]  out8;
  logic [2:0]  sel;
  logic        busy, valid, div0, ovf;
  logic [31:0] nx, ns, freq;
  logic [31:0] m_nx = '0, m_ns = '0;
  logic [63:0] mm;

  int n_chk = 0, n_fail = 0;
  logic [31:0] lx = '0, ls = '0, lf = '0;
  logic        ld = 1'b0, lo = 1'b0;

  cpj_readout #(.FSTD(FSTD), .SETTLE(SETTLE)) dut (
    .clkin(clkin), .clr0(clr0), .int1(int1), .out8(out8), .sel(sel), .busy(busy),
    .nx(nx), .ns(ns), .freq(freq), .valid(valid), .div0(div0), .ovf(ovf)
  );

  always #5 clkin = ~clkin;

  // Meter model: the selected byte of {Ns, Nx} is presented combinationally.
  always_comb begin
    mm   = {m_ns, m_nx};
    out8 = mm[{sel, 3'b000} +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, 64'(sel), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_valid"}, 64'(valid), 0);
    chk({tag, "_nx"}, 64'(nx), 0);
    chk({tag, "_ns"}, 64'(ns), 0);
    chk({tag, "_freq"}, 64'(freq), 0);
    chk({tag, "_div0"}, 64'(div0), 0);
    chk({tag, "_ovf"}, 64'(ovf), 0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit do_sel);
    int n, lat;
    bit seen;
    logic [2:0] sq[$];
    logic [63:0] q;
    logic [31:0] ef;
    bit ed, eo;
    m_nx = a;
    m_ns = b;
    int1 = 1'b0;
    repeat (4) @(negedge clkin);
    ed  = (b == 0);
    q   = ed ? 64'd0 : (64'(a) * 64'(FSTD)) / 64'(b);
    eo  = !ed && (q >> 32) != 0;
    ef  = (ed || eo) ? 32'hFFFFFFFF : q[31:0];
    // Two cycles of synchronizer ahead of the capture sequence itself.
    lat = 2 + 8 * (SETTLE + 1) + (ed ? 2 : 66);
    int1 = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(posedge clkin);
      n++;
      @(negedge clkin);
      if (busy && sq.size() < 24) sq.push_back(sel);
      if (valid) seen = 1;
    end
    chk("valid_seen", 64'(seen), 1);
    chk("latency", 64'(n), 64'(lat));
    chk("nx", 64'(nx), 64'(a));
    chk("ns", 64'(ns), 64'(b));
    chk("freq", 64'(freq), 64'(ef));
    chk("div0", 64'(div0), 64'(ed));
    chk("ovf", 64'(ovf), 64'(eo));
    chk("busy_at_valid", 64'(busy), 1);
    @(negedge clkin);
    chk("valid_pulse", 64'(valid), 0);
    chk("busy_drop", 64'(busy), 0);
    if (do_sel) begin
      chk("sel_count", 64'(sq.size()), 24);
      for (int i = 0; i < sq.size(); i++)
        chk("sel_seq", 64'(sq[i]), 64'(i / (SETTLE + 1)));
    end
    lx = a; ls = b; lf = ef; ld = ed; lo = eo;
  endtask

  initial begin
    int n, v;
    repeat (3) @(negedge clkin);
    chk_zero("reset");
    clr0 = 1'b0;
    repeat (2) @(negedge clkin);

    run(32'd1000, 32'd50000000, 0);
    run(32'h12345678, 32'h9ABCDEF0, 1);
    run(32'd3, 32'd7, 0);
    run(32'd5, 32'd0, 0);
    run(32'hFFFFFFFF, 32'd1, 0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = $urandom_range(0, 3);
        default: b = $urandom_range(1000, 100000000);
      endcase
      run(a, b, 0);
    end

    // Abort: int1 falls while byte 3 is being read.
    m_nx = 32'hDEADBEEF;
    m_ns = 32'h00C0FFEE;
    int1 = 1'b0;
    repeat (4) @(negedge clkin);
    int1 = 1'b1;
    n = 0;
    while (sel != 3'd3 && n < 100) begin
      @(negedge clkin);
      n++;
    end
    chk("abort_reach_k3", 64'(sel), 3);
    int1 = 1'b0;
    repeat (3) @(negedge clkin);
    chk("abort_sel", 64'(sel), 0);
    chk("abort_busy", 64'(busy), 0);
    v = 0;
    repeat (100) begin
      @(negedge clkin);
      if (valid) v++;
    end
    chk("abort_novalid", 64'(v), 0);
    chk("abort_nx_kept", 64'(nx), 64'(lx));
    chk("abort_ns_kept", 64'(ns), 64'(ls));
    chk("abort_freq_kept", 64'(freq), 64'(lf));
    chk("abort_div0_kept", 64'(div0), 64'(ld));
    chk("abort_ovf_kept", 64'(ovf), 64'(lo));
    run(32'd123456, 32'd7654321, 0);

    // Reset in the middle of the divide.
    m_nx = 32'd777;
    m_ns = 32'd99;
    int1 = 1'b0;
    repeat (4) @(negedge clkin);
    int1 = 1'b1;
    repeat (50) @(negedge clkin);
    chk("middiv_busy", 64'(busy), 1);
    clr0 = 1'b1;
    #1;
    chk_zero("middiv_reset");
    repeat (2) @(negedge clkin);
    clr0 = 1'b0;
    v = 0;
    n = 0;
    repeat (120) begin
      @(negedge clkin);
      if (valid) v++;
      if (busy) n++;
    end
    chk("held_high_novalid", 64'(v), 0);
    chk("held_high_nobusy", 64'(n), 0);
    run(32'd777, 32'd99, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
